write_back_regfile: RTL and testbench
=====================================

// Module: write_back_regfile
// PURPOSE
//   Write-back stage and general-purpose register file of the 16-bit multi-cycle CPU; sits directly downstream of fetch_mem_wr.
//   Selects ALU result or byte-swapped memory load data, writes the selected value into one of 16 registers,
//   serves two asynchronous read ports to the decoder and keeps a retired-writeback counter for debug.
// PARAMETERS
//   REG_WIDTH   16  data width of every register and write-back path
//   NUM_REGS    16  number of architectural registers (index width fixed at 4 bits)
//   R0_ZERO     1   1: register 0 hardwired to zero, writes to it discarded; 0: R0 is an ordinary register
// PORTS
//   clk              in   1          system clock, all state updates on rising edge
//   rst              in   1          synchronous active-high reset
//   i_R_alu_out      in   REG_WIDTH  registered ALU result from fetch_mem_wr
//   i_16_mem_data    in   16         load data from fetch_mem_wr, already byte-swapped, zero when no load
//   i_1_mem2reg_sel  in   1          1: write back i_16_mem_data; 0: write back i_R_alu_out
//   i_4_reg_wr_addr  in   4          destination register index
//   i_1_reg_wr_en    in   1          write enable, one write per asserted cycle
//   i_4_rd_addr_a    in   4          read port A index (decoder rs)
//   i_4_rd_addr_b    in   4          read port B index (decoder rt)
//   o_R_rd_data_a    out  REG_WIDTH  register[rd_addr_a], combinational
//   o_R_rd_data_b    out  REG_WIDTH  register[rd_addr_b], combinational
//   or_R_wb_data     out  REG_WIDTH  last value written back, registered (debug / trace)
//   or_4_wb_addr     out  4          index of last write-back, registered
//   or_1_wb_valid    out  1          one-cycle pulse the cycle after an accepted write
//   or_16_retire_cnt out  16         count of accepted writes, wraps 0xFFFF -> 0x0000
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): all registers <= 0; or_R_wb_data, or_4_wb_addr, or_1_wb_valid, or_16_retire_cnt <= 0.
//     Any write presented in the reset cycle is dropped; reset wins over every simultaneous event.
//   - wb_data = i_1_mem2reg_sel ? i_16_mem_data (zero-extended/truncated to REG_WIDTH) : i_R_alu_out.
//   - Accepted write = i_1_reg_wr_en & ~rst. On accept: reg[i_4_reg_wr_addr] <= wb_data at that edge (latency 1),
//     except index 0 when R0_ZERO=1 (storage unchanged, still reads 0).
//   - Trace regs update on every accepted write, incl. discarded R0 writes: or_R_wb_data <= wb_data,
//     or_4_wb_addr <= addr, or_1_wb_valid <= 1; otherwise or_1_wb_valid <= 0, data/addr hold.
//   - or_16_retire_cnt += 1 per accepted write; wrap-around silent, no saturation.
//   - Reads are asynchronous; index 0 with R0_ZERO=1 always returns 0.
//   - Back-to-back writes to the same index: last write wins, one per cycle, no stall.
//   - Read of index being written in same cycle: see CONFIGURATION.
// CONFIGURATION
//   Macro WB_BYPASS_EN:
//     defined   - read port whose index equals an accepted write address (non-zero when R0_ZERO=1) returns wb_data
//                 in the same cycle (write-through forwarding).
//     undefined - read returns the pre-write register contents; new value visible from the next cycle.
// STRUCTURE
//   - Shared package cpu_pkg: REG_WIDTH, REG_IDX_W=4, REG_ZERO=4'd0, REG_LINK=4'd15, WB_SEL_ALU=1'b0, WB_SEL_MEM=1'b1.
//   - One sub-module: regfile_mem (NUM_REGS x REG_WIDTH array, 1 sync write port, 2 async read ports, R0_ZERO handling).
//     Top level holds the write-back mux, bypass logic, trace registers and retire counter.
// TESTING
//   1. Reset then read all 16 indices -> all 0; counter 0, wb_valid 0.
//   2. wr_en=1, addr=3, sel=0, alu=0x1234 -> next cycle rd_a(3)=0x1234, wb_valid pulse, wb_addr=3, cnt=1.
//   3. wr_en=1, addr=5, sel=1, mem=0xBEEF, alu=0x1111 -> reg5=0xBEEF (mem path taken, alu ignored).
//   4. Write 0xFFFF to R0 (R0_ZERO=1) -> rd(0)=0, cnt increments, wb_data=0xFFFF.
//   5. Same-cycle write 0x00AA to R7 with rd_b=7: bypass build -> 0x00AA that cycle; plain build -> old value, 0x00AA next cycle.
//   6. Preload cnt=0xFFFF via 65535 writes, one more -> cnt=0x0000; assert rst with wr_en=1, addr=2 -> reg2=0, cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and write-back source select encodings.
package cpu_pkg;

   localparam int unsigned REG_WIDTH = 16;
   localparam int unsigned REG_IDX_W = 4;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 4'd0;
   localparam logic [REG_IDX_W-1:0] REG_LINK = 4'd15;

   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mem.sv
// General-purpose register array: one synchronous write port, two asynchronous read ports,
// optional hardwired-zero R0.
module regfile_mem #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NUM_REGS = 16,
   parameter bit          R0_ZERO  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [3:0]       wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [3:0]       rd_addr_a_i,
   input  logic [3:0]       rd_addr_b_i,
   output logic [WIDTH-1:0] rd_data_a_o,
   output logic [WIDTH-1:0] rd_data_b_o
);
   import cpu_pkg::*;

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic             wr_keep_c;

   // Writes to R0 are dropped when it is hardwired to zero.
   assign wr_keep_c = wr_en_i && !(R0_ZERO && (wr_addr_i == REG_ZERO));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_keep_c) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_a_o = (R0_ZERO && (rd_addr_a_i == REG_ZERO)) ? '0 : regs_q[rd_addr_a_i];
   assign rd_data_b_o = (R0_ZERO && (rd_addr_b_i == REG_ZERO)) ? '0 : regs_q[rd_addr_b_i];

endmodule

// File: rtl/write_back_regfile.sv
// Write-back stage: result mux, register file, optional same-cycle forwarding (WB_BYPASS_EN),
// trace registers and retired-writeback counter.
module write_back_regfile #(
   parameter int unsigned REG_WIDTH = 16,
   parameter int unsigned NUM_REGS  = 16,
   parameter bit          R0_ZERO   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_WIDTH-1:0] i_R_alu_out,
   input  logic [15:0]          i_16_mem_data,
   input  logic                 i_1_mem2reg_sel,
   input  logic [3:0]           i_4_reg_wr_addr,
   input  logic                 i_1_reg_wr_en,
   input  logic [3:0]           i_4_rd_addr_a,
   input  logic [3:0]           i_4_rd_addr_b,
   output logic [REG_WIDTH-1:0] o_R_rd_data_a,
   output logic [REG_WIDTH-1:0] o_R_rd_data_b,
   output logic [REG_WIDTH-1:0] or_R_wb_data,
   output logic [3:0]           or_4_wb_addr,
   output logic                 or_1_wb_valid,
   output logic [15:0]          or_16_retire_cnt
);
   import cpu_pkg::*;

   logic [REG_WIDTH-1:0] wb_data_c;
   logic                 wr_acc_c;
   logic [REG_WIDTH-1:0] mem_rd_a_c;
   logic [REG_WIDTH-1:0] mem_rd_b_c;

   logic [REG_WIDTH-1:0] wb_data_q, wb_data_d;
   logic [3:0]           wb_addr_q, wb_addr_d;
   logic                 wb_valid_q, wb_valid_d;
   logic [15:0]          retire_cnt_q, retire_cnt_d;

   assign wb_data_c = (i_1_mem2reg_sel == WB_SEL_MEM) ? REG_WIDTH'(i_16_mem_data) : i_R_alu_out;
   assign wr_acc_c  = i_1_reg_wr_en & ~rst;

   regfile_mem #(
      .WIDTH    (REG_WIDTH),
      .NUM_REGS (NUM_REGS),
      .R0_ZERO  (R0_ZERO)
   ) u_regfile_mem (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (wr_acc_c),
      .wr_addr_i   (i_4_reg_wr_addr),
      .wr_data_i   (wb_data_c),
      .rd_addr_a_i (i_4_rd_addr_a),
      .rd_addr_b_i (i_4_rd_addr_b),
      .rd_data_a_o (mem_rd_a_c),
      .rd_data_b_o (mem_rd_b_c)
   );

`ifdef WB_BYPASS_EN
   // Write-through forwarding; a discarded R0 write must never be forwarded.
   logic fwd_ok_c;
   assign fwd_ok_c      = wr_acc_c && !(R0_ZERO && (i_4_reg_wr_addr == REG_ZERO));
   assign o_R_rd_data_a = (fwd_ok_c && (i_4_rd_addr_a == i_4_reg_wr_addr)) ? wb_data_c : mem_rd_a_c;
   assign o_R_rd_data_b = (fwd_ok_c && (i_4_rd_addr_b == i_4_reg_wr_addr)) ? wb_data_c : mem_rd_b_c;
`else
   assign o_R_rd_data_a = mem_rd_a_c;
   assign o_R_rd_data_b = mem_rd_b_c;
`endif

   // Trace and retire counter next-state; discarded R0 writes still count as retired.
   always_comb begin
      wb_data_d    = wb_data_q;
      wb_addr_d    = wb_addr_q;
      wb_valid_d   = 1'b0;
      retire_cnt_d = retire_cnt_q;
      if (wr_acc_c) begin
         wb_data_d    = wb_data_c;
         wb_addr_d    = i_4_reg_wr_addr;
         wb_valid_d   = 1'b1;
         retire_cnt_d = retire_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data_q    <= '0;
         wb_addr_q    <= '0;
         wb_valid_q   <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         wb_data_q    <= wb_data_d;
         wb_addr_q    <= wb_addr_d;
         wb_valid_q   <= wb_valid_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign or_R_wb_data     = wb_data_q;
   assign or_4_wb_addr     = wb_addr_q;
   assign or_1_wb_valid    = wb_valid_q;
   assign or_16_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_write_back_regfile.sv
// Directed bench for write_back_regfile; expectations follow the WB_BYPASS_EN setting of the build.
module tb_write_back_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] alu;
   logic [15:0] mem;
   logic        sel;
   logic [3:0]  wr_addr;
   logic        wr_en;
   logic [3:0]  rd_a;
   logic [3:0]  rd_b;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic [15:0] wb_data;
   logic [3:0]  wb_addr;
   logic        wb_valid;
   logic [15:0] retire_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   write_back_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .i_R_alu_out      (alu),
      .i_16_mem_data    (mem),
      .i_1_mem2reg_sel  (sel),
      .i_4_reg_wr_addr  (wr_addr),
      .i_1_reg_wr_en    (wr_en),
      .i_4_rd_addr_a    (rd_a),
      .i_4_rd_addr_b    (rd_b),
      .o_R_rd_data_a    (rd_data_a),
      .o_R_rd_data_b    (rd_data_b),
      .or_R_wb_data     (wb_data),
      .or_4_wb_addr     (wb_addr),
      .or_1_wb_valid    (wb_valid),
      .or_16_retire_cnt (retire_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic en, input logic [3:0] a, input logic s,
                         input logic [15:0] al, input logic [15:0] me);
      wr_en = en; wr_addr = a; sel = s; alu = al; mem = me;
   endtask

   initial begin
      int n_fill;
      rst = 1'b1; set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_a = 4'd0; rd_b = 4'd0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // Reset state
      for (int i = 0; i < 16; i++) begin
         rd_a = 4'(i); rd_b = 4'(15 - i);
         #1;
         check("reset_rd_a", rd_data_a, 16'h0000);
         check("reset_rd_b", rd_data_b, 16'h0000);
      end
      check("reset_cnt", retire_cnt, 16'h0000);
      check("reset_valid", 16'(wb_valid), 16'h0000);
      check("reset_wb_data", wb_data, 16'h0000);

      // ALU write to R3
      set_wr(1'b1, 4'd3, 1'b0, 16'h1234, 16'h0000);
      tick();
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_a = 4'd3;
      #1;
      check("alu_wr_rd3", rd_data_a, 16'h1234);
      check("alu_wr_valid", 16'(wb_valid), 16'h0001);
      check("alu_wr_addr", 16'(wb_addr), 16'h0003);
      check("alu_wr_data", wb_data, 16'h1234);
      check("alu_wr_cnt", retire_cnt, 16'h0001);
      tick();
      check("valid_pulse_end", 16'(wb_valid), 16'h0000);
      check("wb_data_hold", wb_data, 16'h1234);

      // Memory path to R5, ALU value ignored
      set_wr(1'b1, 4'd5, 1'b1, 16'h1111, 16'hBEEF);
      tick();
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_b = 4'd5;
      #1;
      check("mem_wr_rd5", rd_data_b, 16'hBEEF);
      check("mem_wr_data", wb_data, 16'hBEEF);
      check("mem_wr_cnt", retire_cnt, 16'h0002);

      // R0 hardwired zero
      set_wr(1'b1, 4'd0, 1'b0, 16'hFFFF, 16'h0000);
      tick();
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_a = 4'd0;
      #1;
      check("r0_rd", rd_data_a, 16'h0000);
      check("r0_cnt", retire_cnt, 16'h0003);
      check("r0_wb_data", wb_data, 16'hFFFF);
      check("r0_wb_addr", 16'(wb_addr), 16'h0000);
      check("r0_valid", 16'(wb_valid), 16'h0001);

      // Same-cycle read of R7 while it is written
      set_wr(1'b1, 4'd7, 1'b0, 16'h0055, 16'h0000);
      tick();
      set_wr(1'b1, 4'd7, 1'b0, 16'h00AA, 16'h0000); rd_b = 4'd7;
      #1;
`ifdef WB_BYPASS_EN
      check("same_cycle_r7", rd_data_b, 16'h00AA);
`else
      check("same_cycle_r7", rd_data_b, 16'h0055);
`endif
      tick();
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0);
      #1;
      check("next_cycle_r7", rd_data_b, 16'h00AA);
      check("r7_cnt", retire_cnt, 16'h0005);

      // R0 write must never be forwarded
      set_wr(1'b1, 4'd0, 1'b0, 16'h5A5A, 16'h0000); rd_a = 4'd0;
      #1;
      check("r0_no_fwd", rd_data_a, 16'h0000);
      tick();

      // Back-to-back writes to R9, last wins
      set_wr(1'b1, 4'd9, 1'b0, 16'h0001, 16'h0000);
      tick();
      set_wr(1'b1, 4'd9, 1'b1, 16'h0000, 16'h0002);
      tick();
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_a = 4'd9;
      #1;
      check("b2b_r9", rd_data_a, 16'h0002);
      check("b2b_cnt", retire_cnt, 16'h0008);
      check("other_reg_r3", rd_data_a == 16'h0002 ? 16'h0 : 16'h1, 16'h0000);

      // Fill counter to 0xFFFF, then wrap
      n_fill = 16'hFFFF - 8;
      for (int i = 0; i < n_fill; i++) begin
         set_wr(1'b1, 4'd4, 1'b0, 16'(i), 16'h0000);
         tick();
      end
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_b = 4'd4;
      #1;
      check("cnt_ffff", retire_cnt, 16'hFFFF);
      check("fill_last_r4", rd_data_b, 16'(n_fill - 1));
      set_wr(1'b1, 4'd2, 1'b0, 16'h2222, 16'h0000);
      tick();
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_a = 4'd2;
      #1;
      check("cnt_wrap", retire_cnt, 16'h0000);
      check("r2_before_rst", rd_data_a, 16'h2222);

      // Reset beats a simultaneous write
      rst = 1'b1;
      set_wr(1'b1, 4'd2, 1'b0, 16'h3333, 16'h0000);
      tick();
      rst = 1'b0;
      set_wr(1'b0, 4'd0, 1'b0, 16'h0, 16'h0); rd_a = 4'd2; rd_b = 4'd3;
      #1;
      check("rst_r2", rd_data_a, 16'h0000);
      check("rst_r3", rd_data_b, 16'h0000);
      check("rst_cnt", retire_cnt, 16'h0000);
      check("rst_valid", 16'(wb_valid), 16'h0000);
      check("rst_wb_data", wb_data, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
